// File: rtl/raster_pkg.sv
// rtl/raster_pkg.sv - raster constants and scan state shared by the bbox, scan and edge-test stages
package raster_pkg;

    localparam int COORD_W    = 16;
    localparam int FRAC       = 6;
    localparam int PIXEL_STEP = 64;
    localparam int HALF_PIXEL = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } scan_state_e;

endpackage

// File: rtl/axis_stepper.sv
// rtl/axis_stepper.sv - one scan axis: registered coordinate with load/step/reload and at-max flag
//   clk_i, rst_i          : clock, synchronous active-high reset
//   load_i, min_i, max_i  : capture new bounds; coordinate starts at min_i
//   step_i, reload_i      : advance by STEP, or return to the captured minimum
//   sample_o              : registered coordinate + OFFSET
//   at_max_o              : registered (coordinate == captured maximum)
module axis_stepper #(
    parameter int             W      = 16,
    parameter logic [W-1:0]   STEP   = W'(64),
    parameter logic [W-1:0]   OFFSET = W'(32)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] min_i,
    input  logic [W-1:0] max_i,
    input  logic         step_i,
    input  logic         reload_i,
    output logic [W-1:0] sample_o,
    output logic         at_max_o
);

    logic [W-1:0] min_q,    min_d;
    logic [W-1:0] max_q,    max_d;
    logic [W-1:0] coord_q,  coord_d;
    logic [W-1:0] sample_q, sample_d;
    logic         at_max_q, at_max_d;
    logic         upd;

    assign upd = load_i | step_i | reload_i;

    always_comb begin
        min_d   = min_q;
        max_d   = max_q;
        coord_d = coord_q;
        if (load_i) begin
            min_d   = min_i;
            max_d   = max_i;
            coord_d = min_i;
        end else if (reload_i) begin
            coord_d = min_q;
        end else if (step_i) begin
            coord_d = coord_q + STEP;
        end
        // The compare is made on the un-wrapped target, so a max at the top
        // of the range still terminates even though the next step would wrap.
        at_max_d = (coord_d == max_d);
        sample_d = coord_d + OFFSET;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            min_q    <= '0;
            max_q    <= '0;
            coord_q  <= '0;
            sample_q <= '0;
            at_max_q <= 1'b0;
        end else if (upd) begin
            min_q    <= min_d;
            max_q    <= max_d;
            coord_q  <= coord_d;
            sample_q <= sample_d;
            at_max_q <= at_max_d;
        end
    end

    assign sample_o = sample_q;
    assign at_max_o = at_max_q;

endmodule

// File: rtl/bbox_sample_scanner.sv
// rtl/bbox_sample_scanner.sv - walks each pixel of a bounding box in raster order, one centre sample per pixel
//   CLK, RST                         : clock, synchronous active-high reset
//   bbox_valid/bbox_ready            : box handshake, XMIN/XMAX/YMIN/YMAX sampled at capture
//   sample_valid/sample_ready        : sample stream with sample_x, sample_y, sample_last
//   done                             : one-cycle pulse after a box finishes or is rejected as empty
module bbox_sample_scanner
    import raster_pkg::*;
#(
    parameter int WIDTH         = raster_pkg::COORD_W,
    parameter int FRAC          = raster_pkg::FRAC,
    parameter int SAMPLE_OFFSET = raster_pkg::HALF_PIXEL
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             bbox_valid,
    output logic             bbox_ready,
    input  logic [WIDTH-1:0] XMIN,
    input  logic [WIDTH-1:0] XMAX,
    input  logic [WIDTH-1:0] YMIN,
    input  logic [WIDTH-1:0] YMAX,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [WIDTH-1:0] sample_x,
    output logic [WIDTH-1:0] sample_y,
    output logic             sample_last,
    output logic             done
);

    localparam logic [WIDTH-1:0] STEP      = WIDTH'(1) << FRAC;
    localparam logic [WIDTH-1:0] FRAC_MASK = ~(STEP - WIDTH'(1));
    localparam logic [WIDTH-1:0] OFFSET    = WIDTH'(SAMPLE_OFFSET);

    scan_state_e state_q;
    logic        bbox_ready_q;
    logic        sample_valid_q;
    logic        done_q;

    logic [WIDTH-1:0] xmin_c, xmax_c, ymin_c, ymax_c;
    logic             box_empty;
    logic             take, load, hs;
    logic             x_at_max, y_at_max, is_last;
    logic             x_step, x_reload, y_step;

    // Boxes arrive rounded to pixels; any stray fractional bits are dropped.
    assign xmin_c    = XMIN & FRAC_MASK;
    assign xmax_c    = XMAX & FRAC_MASK;
    assign ymin_c    = YMIN & FRAC_MASK;
    assign ymax_c    = YMAX & FRAC_MASK;
    assign box_empty = (xmin_c > xmax_c) || (ymin_c > ymax_c);

    assign take     = (state_q == IDLE) && bbox_valid && bbox_ready_q;
    assign load     = take && !box_empty;
    assign hs       = (state_q == SCAN) && sample_ready;
    assign is_last  = x_at_max && y_at_max;
    assign x_step   = hs && !x_at_max;
    assign x_reload = hs && x_at_max && !y_at_max;
    assign y_step   = x_reload;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            bbox_ready_q   <= 1'b0;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (take) begin
                        bbox_ready_q <= 1'b0;
                        if (box_empty) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q        <= SCAN;
                            sample_valid_q <= 1'b1;
                        end
                    end else begin
                        // Covers the first idle cycle after reset release.
                        bbox_ready_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (hs && is_last) begin
                        state_q        <= FINISH;
                        sample_valid_q <= 1'b0;
                        done_q         <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q      <= IDLE;
                    done_q       <= 1'b0;
                    bbox_ready_q <= 1'b1;
                end
                default: begin
                    state_q        <= IDLE;
                    bbox_ready_q   <= 1'b0;
                    sample_valid_q <= 1'b0;
                    done_q         <= 1'b0;
                end
            endcase
        end
    end

    axis_stepper #(.W(WIDTH), .STEP(STEP), .OFFSET(OFFSET)) u_x (
        .clk_i    (CLK),
        .rst_i    (RST),
        .load_i   (load),
        .min_i    (xmin_c),
        .max_i    (xmax_c),
        .step_i   (x_step),
        .reload_i (x_reload),
        .sample_o (sample_x),
        .at_max_o (x_at_max)
    );

    axis_stepper #(.W(WIDTH), .STEP(STEP), .OFFSET(OFFSET)) u_y (
        .clk_i    (CLK),
        .rst_i    (RST),
        .load_i   (load),
        .min_i    (ymin_c),
        .max_i    (ymax_c),
        .step_i   (y_step),
        .reload_i (1'b0),
        .sample_o (sample_y),
        .at_max_o (y_at_max)
    );

    assign bbox_ready   = bbox_ready_q;
    assign sample_valid = sample_valid_q;
    // Both flags are registers; gating with the registered valid keeps it low outside SCAN.
    assign sample_last  = sample_valid_q && is_last;
    assign done         = done_q;

endmodule

// File: tb/tb_bbox_sample_scanner.sv
// tb/tb_bbox_sample_scanner.sv - self-checking bench for bbox_sample_scanner
module tb_bbox_sample_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        bbox_valid;
    logic        bbox_ready;
    logic [15:0] xmin, xmax, ymin, ymax;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] sample_x, sample_y;
    logic        sample_last;
    logic        done;

    always #5 clk = ~clk;

    bbox_sample_scanner dut (
        .CLK          (clk),
        .RST          (rst),
        .bbox_valid   (bbox_valid),
        .bbox_ready   (bbox_ready),
        .XMIN         (xmin),
        .XMAX         (xmax),
        .YMIN         (ymin),
        .YMAX         (ymax),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_last  (sample_last),
        .done         (done)
    );

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
    } samp_t;

    samp_t got_q[$];
    samp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    int done_cyc, last_hs, stab_errs, ready_ok, tail_bad, busy_bad, valid_seen;

    // Reference: every pixel of the rounded box, rows bottom to top, left to right.
    function automatic void build_model(input logic [15:0] x0, x1, y0, y1);
        int a, b, c, d;
        samp_t s;
        exp_q.delete();
        a = int'({16'h0, x0 & 16'hFFC0});
        b = int'({16'h0, x1 & 16'hFFC0});
        c = int'({16'h0, y0 & 16'hFFC0});
        d = int'({16'h0, y1 & 16'hFFC0});
        for (int yy = c; yy <= d; yy += 64) begin
            for (int xx = a; xx <= b; xx += 64) begin
                s.x    = 16'(xx + 32);
                s.y    = 16'(yy + 32);
                s.last = (xx == b) && (yy == d);
                exp_q.push_back(s);
            end
        end
    endfunction

    function automatic int count_diffs();
        int n, lim;
        n   = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size()
                                             : exp_q.size() - got_q.size();
        lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++)
            if (got_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    // Drives one box and records every accepted sample plus timing facts; no judging here.
    task automatic run_box(input logic [15:0] x0, x1, y0, y1, input int mode);
        logic  pv, pr, r;
        samp_t ps, cs;
        got_q.delete();
        done_cyc = -1; last_hs = -1; stab_errs = 0; ready_ok = 0;
        tail_bad = 0; busy_bad = 0; valid_seen = 0;
        pv = 1'b0; pr = 1'b0; ps = '0;
        @(negedge clk);
        xmin = x0; xmax = x1; ymin = y0; ymax = y1;
        bbox_valid = 1'b1;
        sample_ready = 1'b0;
        @(posedge clk);
        #1;
        bbox_valid = 1'b0;
        xmin = 16'($urandom); xmax = 16'($urandom);
        ymin = 16'($urandom); ymax = 16'($urandom);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            cs.x = sample_x; cs.y = sample_y; cs.last = sample_last;
            if (done_cyc < 0) begin
                if (done === 1'b1) begin
                    done_cyc = cyc;
                    if (sample_valid !== 1'b0) tail_bad++;
                end else if (bbox_ready !== 1'b0) begin
                    busy_bad++;
                end
                if (sample_valid === 1'b1) valid_seen++;
                if (pv && !pr && (sample_valid !== 1'b1 || cs !== ps)) stab_errs++;
                case (mode)
                    0:       r = 1'b1;
                    1:       r = ((cyc - 1) % 3 == 0);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                sample_ready = r;
                if (sample_valid === 1'b1 && r) begin
                    got_q.push_back(cs);
                    last_hs = cyc;
                end
                pv = (sample_valid === 1'b1); pr = r; ps = cs;
            end else begin
                ready_ok = (bbox_ready === 1'b1) ? 1 : 0;
                if (done !== 1'b0 || sample_valid !== 1'b0) tail_bad++;
                break;
            end
        end
        sample_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bbox_valid = 1'b0; sample_ready = 1'b0;
        xmin = '0; xmax = '0; ymin = '0; ymax = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bbox_ready !== 1'b0) begin failures++; $display("FAIL reset_bbox_ready got=%b exp=0", bbox_ready); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_sample_valid got=%b exp=0", sample_valid); end
        checks++; if (sample_x !== 16'h0) begin failures++; $display("FAIL reset_sample_x got=%h exp=0000", sample_x); end
        checks++; if (sample_y !== 16'h0) begin failures++; $display("FAIL reset_sample_y got=%h exp=0000", sample_y); end
        checks++; if (sample_last !== 1'b0) begin failures++; $display("FAIL reset_sample_last got=%b exp=0", sample_last); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bbox_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", bbox_ready); end
        checks++; if (sample_x !== 16'h0 || sample_valid !== 1'b0) begin failures++; $display("FAIL reset_release_idle got x=%h v=%b exp x=0000 v=0", sample_x, sample_valid); end
    endtask

    task automatic test_basic();
        run_box(16'h0040, 16'h00C0, 16'h0080, 16'h00C0, 0);
        build_model(16'h0040, 16'h00C0, 16'h0080, 16'h00C0);
        checks++; if (got_q.size() !== 6) begin failures++; $display("FAIL basic_count got=%0d exp=6", got_q.size()); end
        checks++; if (count_diffs() !== 0) begin failures++; $display("FAIL basic_stream got=%0d differing samples exp=0", count_diffs()); end
        checks++; if (last_hs !== 6) begin failures++; $display("FAIL basic_back_to_back last_handshake_cycle got=%0d exp=6", last_hs); end
        checks++; if (done_cyc !== 7) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=7", done_cyc); end
        checks++; if (ready_ok !== 1) begin failures++; $display("FAIL basic_ready_after_done got=%0d exp=1", ready_ok); end
        checks++; if (tail_bad !== 0 || busy_bad !== 0) begin failures++; $display("FAIL basic_tail got tail=%0d busy=%0d exp 0/0", tail_bad, busy_bad); end
    endtask

    task automatic test_stall();
        run_box(16'h0040, 16'h00C0, 16'h0080, 16'h00C0, 1);
        build_model(16'h0040, 16'h00C0, 16'h0080, 16'h00C0);
        checks++; if (count_diffs() !== 0) begin failures++; $display("FAIL stall_stream got=%0d differing samples exp=0", count_diffs()); end
        checks++; if (stab_errs !== 0) begin failures++; $display("FAIL stall_stability got=%0d unstable cycles exp=0", stab_errs); end
        checks++; if (done_cyc !== last_hs + 1) begin failures++; $display("FAIL stall_done_cycle got=%0d exp=%0d", done_cyc, last_hs + 1); end
    endtask

    task automatic test_single();
        run_box(16'h0100, 16'h0100, 16'h0100, 16'h0100, 0);
        checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== {16'h0120, 16'h0120, 1'b1}) begin failures++; $display("FAIL single_sample got=%h exp=%h", got_q[0], {16'h0120, 16'h0120, 1'b1}); end
        end
        checks++; if (done_cyc !== 2) begin failures++; $display("FAIL single_done_cycle got=%0d exp=2", done_cyc); end
    endtask

    task automatic test_empty_unaligned();
        run_box(16'h0080, 16'h0040, 16'h0000, 16'h0000, 0);
        checks++; if (valid_seen !== 0) begin failures++; $display("FAIL empty_valid got=%0d valid cycles exp=0", valid_seen); end
        checks++; if (done_cyc !== 1) begin failures++; $display("FAIL empty_done_cycle got=%0d exp=1", done_cyc); end
        checks++; if (ready_ok !== 1) begin failures++; $display("FAIL empty_ready got=%0d exp=1", ready_ok); end
        run_box(16'h0047, 16'h00C5, 16'h0013, 16'h0013, 0);
        build_model(16'h0047, 16'h00C5, 16'h0013, 16'h0013);
        checks++; if (got_q.size() < 1 || got_q[0].x !== 16'h0060) begin failures++; $display("FAIL unaligned_first_x got=%h exp=0060", (got_q.size() > 0) ? got_q[0].x : 16'hxxxx); end
        checks++; if (count_diffs() !== 0) begin failures++; $display("FAIL unaligned_stream got=%0d differing samples exp=0", count_diffs()); end
    endtask

    task automatic test_wrap();
        run_box(16'hFF80, 16'hFFC0, 16'h0000, 16'h0000, 0);
        checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== {16'hFFA0, 16'h0020, 1'b0} || got_q[1] !== {16'hFFE0, 16'h0020, 1'b1}) begin
                failures++; $display("FAIL wrap_samples got=%h,%h exp=%h,%h", got_q[0], got_q[1], {16'hFFA0, 16'h0020, 1'b0}, {16'hFFE0, 16'h0020, 1'b1});
            end
        end
        checks++; if (done_cyc !== 3) begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=3", done_cyc); end
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clk);
        xmin = 16'h0000; xmax = 16'h0080; ymin = 16'h0000; ymax = 16'h0080;
        bbox_valid = 1'b1; sample_ready = 1'b1;
        @(posedge clk);
        #1 bbox_valid = 1'b0;
        @(negedge clk);
        checks++; if (sample_valid !== 1'b1 || sample_x !== 16'h0020) begin failures++; $display("FAIL rstmid_first got v=%b x=%h exp v=1 x=0020", sample_valid, sample_x); end
        @(negedge clk);
        checks++; if (sample_x !== 16'h0060) begin failures++; $display("FAIL rstmid_second got x=%h exp=0060", sample_x); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_abort got v=%b done=%b exp 0/0", sample_valid, done); end
        rst = 1'b0; sample_ready = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || sample_valid !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_quiet got=%0d active cycles exp=0", bad); end
        checks++; if (bbox_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", bbox_ready); end
        run_box(16'h0100, 16'h0140, 16'h0040, 16'h0040, 0);
        build_model(16'h0100, 16'h0140, 16'h0040, 16'h0040);
        checks++; if (count_diffs() !== 0) begin failures++; $display("FAIL rstmid_newbox got=%0d differing samples exp=0", count_diffs()); end
    endtask

    task automatic test_random();
        logic [15:0] x0, x1, y0, y1;
        int kind, mode, exp_done;
        for (int b = 0; b < 24; b++) begin
            kind = $urandom_range(0, 9);
            mode = $urandom_range(0, 2);
            if (kind == 0) begin
                x0 = 16'(16'h0200 + $urandom_range(0, 16'h03FF));
                x1 = 16'(x0 - 64 - $urandom_range(0, 63));
                y0 = 16'($urandom_range(0, 16'h0FFF));
                y1 = 16'(y0 + $urandom_range(0, 16'h00BF));
            end else if (kind == 1) begin
                x0 = 16'(16'hFF00 + $urandom_range(0, 16'h00BF));
                x1 = 16'(16'hFFFF - $urandom_range(0, 16'h003F));
                y0 = 16'(16'hFF40 + $urandom_range(0, 16'h007F));
                y1 = 16'(16'hFFFF - $urandom_range(0, 16'h003F));
            end else begin
                x0 = 16'($urandom_range(0, 16'h3FFF));
                x1 = 16'(x0 + $urandom_range(0, 16'h013F));
                y0 = 16'($urandom_range(0, 16'h3FFF));
                y1 = 16'(y0 + $urandom_range(0, 16'h00BF));
            end
            run_box(x0, x1, y0, y1, mode);
            build_model(x0, x1, y0, y1);
            exp_done = (exp_q.size() == 0) ? 1 : last_hs + 1;
            checks++; if (count_diffs() !== 0) begin failures++; $display("FAIL rand_stream box=%0d got=%0d diffs (n=%0d) exp=0 (n=%0d)", b, count_diffs(), got_q.size(), exp_q.size()); end
            checks++; if (done_cyc !== exp_done) begin failures++; $display("FAIL rand_done box=%0d got=%0d exp=%0d", b, done_cyc, exp_done); end
            checks++; if (stab_errs !== 0 || tail_bad !== 0 || busy_bad !== 0 || ready_ok !== 1) begin
                failures++; $display("FAIL rand_protocol box=%0d got stab=%0d tail=%0d busy=%0d ready=%0d exp 0/0/0/1", b, stab_errs, tail_bad, busy_bad, ready_ok);
            end
            if (mode == 0 && exp_q.size() > 0) begin
                checks++; if (last_hs !== exp_q.size()) begin failures++; $display("FAIL rand_throughput box=%0d got=%0d exp=%0d", b, last_hs, exp_q.size()); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_single();
        test_empty_unaligned();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
